// File: rtl/unidad_control_multiciclo_if.sv
`default_nettype none
// ============================================================================
//  Module   : unidad_control_multiciclo_if
//  Brief    : Instruction-field / control-line bundle between the instruction
//             register + datapath (master) and the multicycle control unit
//             (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface unidad_control_multiciclo_if #(
  parameter int ALU_CTRL_W = 4
);
  // Instruction fields and live ALU flags.
  logic [3:0]            cond;
  logic [1:0]            op;
  logic [5:0]            funct;
  logic [3:0]            rd;
  logic [3:0]            ALU_flags;
  // Datapath control lines.
  logic                  PC_write;
  logic                  IR_write;
  logic                  reg_write;
  logic                  mem_write;
  logic                  adr_src;
  logic                  ALU_src_a;
  logic [1:0]            ALU_src_b;
  logic [1:0]            result_src;
  logic [1:0]            imm_src;
  logic [1:0]            reg_src;
  logic [ALU_CTRL_W-1:0] ALU_control;
  logic [3:0]            state_dbg;

  // Control unit side.
  modport slave (
    input  cond, op, funct, rd, ALU_flags,
    output PC_write, IR_write, reg_write, mem_write, adr_src, ALU_src_a,
           ALU_src_b, result_src, imm_src, reg_src, ALU_control, state_dbg
  );

  // Datapath / instruction register side.
  modport master (
    output cond, op, funct, rd, ALU_flags,
    input  PC_write, IR_write, reg_write, mem_write, adr_src, ALU_src_a,
           ALU_src_b, result_src, imm_src, reg_src, ALU_control, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : unidad_control_multiciclo
//  Brief    : Multicycle ARM-subset control unit. 10-state Moore FSM with an
//             internal NZCV register; architectural writes are gated by the
//             condition evaluated on the stored flags.
//             Optional macro UC_MULTI_MEM_HANDSHAKE_EN adds a mem_ready input
//             that stretches FETCH, MEMREAD and MEMWRITE.
//  Revision : 1.0 - initial release
// ============================================================================
module unidad_control_multiciclo #(
  parameter int         ALU_CTRL_W = 4,
  parameter logic [3:0] PC_REG     = 4'd15
) (
  input  wire logic clk,
  input  wire logic rst_n,
`ifdef UC_MULTI_MEM_HANDSHAKE_EN
  input  wire logic mem_ready,
`endif
  unidad_control_multiciclo_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic       ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       cmd_arith;
  logic       cmd_is_cmp;
  logic [1:0] alu_sel;
  logic       cond_ok;
  logic       n_f, z_f, c_f, v_f;
  logic       dp_write;

`ifdef UC_MULTI_MEM_HANDSHAKE_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  assign cmd = bus.funct[4:1];
  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Decode the data-processing command into an ALU select and write qualifiers.
  always_comb begin
    alu_sel    = 2'd0;
    cmd_valid  = 1'b1;
    cmd_arith  = 1'b0;
    cmd_is_cmp = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_sel = 2'd0; cmd_arith = 1'b1; end
      CMD_SUB: begin alu_sel = 2'd1; cmd_arith = 1'b1; end
      CMD_AND: alu_sel = 2'd2;
      CMD_ORR: alu_sel = 2'd3;
      CMD_CMP: begin alu_sel = 2'd1; cmd_arith = 1'b1; cmd_is_cmp = 1'b1; end
      default: cmd_valid = 1'b0;
    endcase
  end

  // Evaluate the condition field against the stored (pre-update) flags.
  always_comb begin
    cond_ok = 1'b0;
    case (bus.cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Register write qualifier for ALUWB: condition passed, legal command, not a compare.
  assign dp_write = cond_ok & cmd_valid & ~cmd_is_cmp;

  // Next-state selection; memory-facing states hold until the memory is ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          2'b00:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Flag update on leaving ALUWB: N/Z always, C/V only for arithmetic commands.
  always_comb begin
    flags_d = flags_q;
    if (state_q == S_ALUWB && cond_ok && cmd_valid && bus.funct[0]) begin
      flags_d[3:2] = bus.ALU_flags[3:2];
      if (cmd_arith) flags_d[1:0] = bus.ALU_flags[1:0];
    end
  end

  // State and flag registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  logic                  pc_write_c, ir_write_c, reg_write_c, mem_write_c;
  logic                  adr_src_c, alu_src_a_c;
  logic [1:0]            alu_src_b_c, result_src_c;
  logic [ALU_CTRL_W-1:0] alu_control_c;

  // Per-state control lines.
  always_comb begin
    pc_write_c    = 1'b0;
    ir_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    mem_write_c   = 1'b0;
    adr_src_c     = 1'b0;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'b00;
    result_src_c  = 2'b00;
    alu_control_c = '0;
    case (state_q)
      S_FETCH: begin
        ir_write_c   = ready;
        pc_write_c   = ready;
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
      end
      S_MEMADR:   alu_src_b_c = 2'b01;
      S_MEMREAD:  adr_src_c   = 1'b1;
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = cond_ok;
      end
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = cond_ok;
      end
      S_EXECR: begin
        alu_src_b_c   = 2'b00;
        alu_control_c = ALU_CTRL_W'(alu_sel);
      end
      S_EXECI: begin
        alu_src_b_c   = 2'b01;
        alu_control_c = ALU_CTRL_W'(alu_sel);
      end
      S_ALUWB: begin
        result_src_c  = 2'b00;
        reg_write_c   = dp_write;
        pc_write_c    = dp_write & (bus.rd == PC_REG);
        alu_control_c = ALU_CTRL_W'(alu_sel);
      end
      S_BRANCH: begin
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        pc_write_c   = cond_ok;
      end
      default: ;
    endcase
  end

  // Every output is held at zero while reset is asserted.
  assign bus.PC_write    = rst_n & pc_write_c;
  assign bus.IR_write    = rst_n & ir_write_c;
  assign bus.reg_write   = rst_n & reg_write_c;
  assign bus.mem_write   = rst_n & mem_write_c;
  assign bus.adr_src     = rst_n & adr_src_c;
  assign bus.ALU_src_a   = rst_n & alu_src_a_c;
  assign bus.ALU_src_b   = rst_n ? alu_src_b_c  : 2'b00;
  assign bus.result_src  = rst_n ? result_src_c : 2'b00;
  assign bus.imm_src     = rst_n ? bus.op       : 2'b00;
  assign bus.reg_src     = rst_n ? {bus.op == 2'b01, bus.op == 2'b10} : 2'b00;
  assign bus.ALU_control = rst_n ? alu_control_c : '0;
  assign bus.state_dbg   = rst_n ? state_q      : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unidad_control_multiciclo
//  Brief    : Directed self-checking bench for the multicycle control unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unidad_control_multiciclo;

  logic clk;
  logic rst_n;
`ifdef UC_MULTI_MEM_HANDSHAKE_EN
  logic mem_ready;
`endif

  int n_tests;
  int n_fail;

  unidad_control_multiciclo_if #(.ALU_CTRL_W(4)) bus ();

  unidad_control_multiciclo #(.ALU_CTRL_W(4), .PC_REG(4'd15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef UC_MULTI_MEM_HANDSHAKE_EN
    .mem_ready(mem_ready),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    bus.cond  = c;
    bus.op    = o;
    bus.funct = f;
    bus.rd    = r;
  endtask

  // Data-processing instruction, starting and ending in FETCH.
  task automatic run_dp(input string tag, input logic [3:0] c, input logic [5:0] f,
                        input logic [3:0] r, input logic [3:0] fl, input logic [3:0] exp_ex,
                        input logic [3:0] exp_alu, input logic exp_rw, input logic exp_pcw);
    set_instr(c, 2'b00, f, r);
    bus.ALU_flags = fl;
    #1;
    check({tag, "_s0"}, bus.state_dbg, 0);
    step();
    check({tag, "_s1"}, bus.state_dbg, 1);
    step();
    check({tag, "_sex"}, bus.state_dbg, exp_ex);
    check({tag, "_aluex"}, bus.ALU_control, exp_alu);
    check({tag, "_srcb"}, bus.ALU_src_b, f[5] ? 2'b01 : 2'b00);
    step();
    check({tag, "_s8"}, bus.state_dbg, 8);
    check({tag, "_rw"}, bus.reg_write, exp_rw);
    check({tag, "_pcw"}, bus.PC_write, exp_pcw);
    check({tag, "_alu8"}, bus.ALU_control, exp_alu);
    step();
  endtask

  // Branch, starting and ending in FETCH.
  task automatic run_br(input string tag, input logic [3:0] c, input logic exp_pcw);
    set_instr(c, 2'b10, 6'b000000, 4'd0);
    #1;
    step();
    check({tag, "_s1"}, bus.state_dbg, 1);
    step();
    check({tag, "_s9"}, bus.state_dbg, 9);
    check({tag, "_pcw"}, bus.PC_write, exp_pcw);
    check({tag, "_res"}, bus.result_src, 2'b10);
    step();
  endtask

  // Load/store, starting and ending in FETCH.
  task automatic run_mem(input string tag, input logic [3:0] c, input logic ld, input logic exp_w);
    set_instr(c, 2'b01, {5'b00000, ld}, 4'd2);
    #1;
    step();
    check({tag, "_s1"}, bus.state_dbg, 1);
    step();
    check({tag, "_s2"}, bus.state_dbg, 2);
    check({tag, "_srcb"}, bus.ALU_src_b, 2'b01);
    step();
    if (ld) begin
      check({tag, "_s3"}, bus.state_dbg, 3);
      check({tag, "_adr"}, bus.adr_src, 1);
      step();
      check({tag, "_s4"}, bus.state_dbg, 4);
      check({tag, "_res"}, bus.result_src, 2'b01);
      check({tag, "_rw"}, bus.reg_write, exp_w);
    end else begin
      check({tag, "_s5"}, bus.state_dbg, 5);
      check({tag, "_adr"}, bus.adr_src, 1);
      check({tag, "_mw"}, bus.mem_write, exp_w);
    end
    step();
    check({tag, "_end"}, bus.state_dbg, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
`ifdef UC_MULTI_MEM_HANDSHAKE_EN
    mem_ready = 1'b1;
`endif
    set_instr(4'hE, 2'b01, 6'b000000, 4'd0);
    bus.ALU_flags = 4'b0000;
    repeat (2) step();
    check("rst_state", bus.state_dbg, 0);
    check("rst_irw", bus.IR_write, 0);
    check("rst_srcb", bus.ALU_src_b, 0);
    check("rst_imm", bus.imm_src, 0);
    rst_n = 1'b1;
    #1;
    check("fetch_state", bus.state_dbg, 0);
    check("fetch_irw", bus.IR_write, 1);
    check("fetch_pcw", bus.PC_write, 1);
    check("fetch_srcb", bus.ALU_src_b, 2'b10);
    check("fetch_srca", bus.ALU_src_a, 1);
    check("imm_src", bus.imm_src, 2'b01);
    check("reg_src", bus.reg_src, 2'b10);

    // flags 0000 -> SUBS loads 0100
    run_dp("add",   4'hE, 6'b001000, 4'd1,  4'b0000, 4'd6, 4'd0, 1'b1, 1'b0);
    run_dp("subs",  4'hE, 6'b100101, 4'd2,  4'b0100, 4'd7, 4'd1, 1'b1, 1'b0);
    run_br("beq",   4'h0, 1'b1);
    run_br("bne",   4'h1, 1'b0);
    run_mem("ldr",  4'hE, 1'b1, 1'b1);
    run_mem("strne",4'h1, 1'b0, 1'b0);
    run_br("beq2",  4'h0, 1'b1);
    run_mem("str",  4'hE, 1'b0, 1'b1);
    run_dp("addpc", 4'hE, 6'b001000, 4'd15, 4'b0000, 4'd6, 4'd0, 1'b1, 1'b1);
    run_dp("addne", 4'h1, 6'b001000, 4'd3,  4'b0000, 4'd6, 4'd0, 1'b0, 1'b0);
    // CMP with C=1 -> flags 0010
    run_dp("cmp",   4'hE, 6'b010101, 4'd4,  4'b0010, 4'd6, 4'd1, 1'b0, 1'b0);
    run_br("bcs",   4'h2, 1'b1);
    run_br("beq3",  4'h0, 1'b0);
    // ANDS with live 1001: N,Z load, C,V keep -> flags 1010
    run_dp("ands",  4'hE, 6'b000001, 4'd5,  4'b1001, 4'd6, 4'd2, 1'b1, 1'b0);
    run_br("bmi",   4'h4, 1'b1);
    run_br("bvs",   4'h6, 1'b0);
    run_br("bcs2",  4'h2, 1'b1);
    run_dp("orr",   4'hE, 6'b011000, 4'd6,  4'b0000, 4'd6, 4'd3, 1'b1, 1'b0);
    // unsupported command: no write, no flag update
    run_dp("eor",   4'hE, 6'b000011, 4'd7,  4'b0100, 4'd6, 4'd0, 1'b0, 1'b0);
    run_br("bne2",  4'h1, 1'b1);
    run_br("blt",   4'hB, 1'b1);
    run_br("bgt",   4'hC, 1'b0);
    run_br("bhi",   4'h8, 1'b1);
    run_dp("nv",    4'hF, 6'b001000, 4'd1,  4'b0000, 4'd6, 4'd0, 1'b0, 1'b0);

    // undefined op: FETCH, DECODE, FETCH
    set_instr(4'hE, 2'b11, 6'b001001, 4'd1);
    #1;
    step();
    check("undef_s1", bus.state_dbg, 1);
    check("undef_nowr", {bus.PC_write, bus.IR_write, bus.reg_write, bus.mem_write}, 0);
    step();
    check("undef_s0", bus.state_dbg, 0);

    // reset pulsed in EXECR
    set_instr(4'hE, 2'b00, 6'b001001, 4'd1);
    bus.ALU_flags = 4'b0100;
    #1;
    step();
    step();
    check("rstx_s6", bus.state_dbg, 6);
    bus.op = 2'b01;
    rst_n = 1'b0;
    #1;
    check("rstx_all0", {bus.PC_write, bus.IR_write, bus.reg_write, bus.mem_write,
                        bus.adr_src, bus.ALU_src_a, bus.ALU_src_b, bus.result_src,
                        bus.imm_src, bus.reg_src, bus.ALU_control, bus.state_dbg}, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("rstx_fetch", bus.state_dbg, 0);
    check("rstx_irw", bus.IR_write, 1);
    run_br("beq_rst", 4'h0, 1'b0);
    run_br("bpl_rst", 4'h5, 1'b1);

`ifdef UC_MULTI_MEM_HANDSHAKE_EN
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("hs_hold_s0", bus.state_dbg, 0);
      check("hs_hold_irw", bus.IR_write, 0);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check("hs_ready_irw", bus.IR_write, 1);
    step();
    check("hs_decode", bus.state_dbg, 1);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Multicycle control unit for the ARM-subset datapath, successor to the single-cycle `unidad_control`. It decodes `cond`/`op`/`funct`/`rd` over a 10-state Moore FSM and holds an internal NZCV flag register. It gates architectural writes with condition evaluation and drives datapath select/enable lines each cycle. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
- `ALU_CTRL_W`, 4: width of `ALU_control`. Encodings below are zero-extended.
- `PC_REG`, 4'd15: register index treated as the PC. A write to it also asserts `PC_write`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cond`  in  4  instruction condition field.
- `op`  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 undefined.
- `funct`  in  6  [5]=I, [4:1]=cmd, [0]=S (for data-proc) or L (for memory).
- `rd`  in  4  destination register.
- `ALU_flags`  in  4  live ALU NZCV, {N,Z,C,V}.
- `PC_write`, `IR_write`, `reg_write`, `mem_write`, `adr_src`, `ALU_src_a`  out  1 each.
- `ALU_src_b`  out  2  00 reg, 01 imm, 10 const 4.
- `result_src`  out  2  00 ALU out, 01 mem data, 10 ALU result bypass.
- `imm_src`, `reg_src`  out  2 each  equal to `op`-derived values as in single-cycle (`imm_src`=`op`; `reg_src`={op==01, op==10}).
- `ALU_control`  out  `ALU_CTRL_W`.
- `state_dbg`  out  4  current state encoding.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- FETCH asserts `IR_write`=1, `PC_write`=1, `ALU_src_a`=1, `ALU_src_b`=10, `result_src`=10, ADD. Next state is DECODE.
- DECODE uses the same ALU selects with no writes. Next state: `op`=01 → MEMADR; `op`=00 → EXECI if `funct[5]`, else EXECR; `op`=10 → BRANCH; `op`=11 → FETCH, with no side effects.
- MEMADR: `ALU_src_a`=0, `ALU_src_b`=01, ADD. Next state is MEMREAD if `funct[0]`, else MEMWRITE.
- MEMREAD: `adr_src`=1. Next state is MEMWB.
- MEMWB: `result_src`=01, `reg_write`=cond_ok. Next state is FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=cond_ok. Next state is FETCH.
- EXECR uses `ALU_src_b`=00; EXECI uses `ALU_src_b`=01. Both go to ALUWB.
- ALUWB: `result_src`=00, `reg_write`=cond_ok & cmd≠CMP, `PC_write`=that same term & `rd`==`PC_REG`. Next state is FETCH.
- BRANCH: `ALU_src_a`=0, `ALU_src_b`=01, ADD, `result_src`=10, `PC_write`=cond_ok. Next state is FETCH.
- ALU decode applies in EXECR, EXECI and ALUWB. cmd 0100 ADD→0, 0010 SUB→1, 0000 AND→2, 1100 ORR→3, 1010 CMP→1. Any other cmd → 0, with writes suppressed. All other states output ADD (0).
- cond_ok is evaluated from the stored flags using standard ARM semantics (EQ through LE, 1110 AL=1). 1111 evaluates to 0.
- Flag update occurs at the ALUWB edge when cond_ok & S:
  - N and Z load from `ALU_flags`.
  - C and V load only for ADD, SUB and CMP.
- Stored flags used in any cycle are the pre-update values.

## Timing
- While `rst_n`=0: state is FETCH, flags are 0000, and every output is forced to 0 (including `state_dbg`=0).
- The first FETCH outputs appear in the cycle after `rst_n` deasserts.
- Outputs are combinational from state, `op`/`funct`/`rd`/`cond`, and stored flags. Inputs must be stable for the whole state.
- Latency per instruction: data-proc 4 cycles, LDR 5, STR 4, B 3, undefined 2.
- A reset asserted mid-instruction aborts it immediately. No partial flag update occurs.
- A failed condition still traverses all states; only writes are suppressed.

## Configuration
- Macro: `UC_MULTI_MEM_HANDSHAKE_EN`.
- When defined, the block adds input `mem_ready` (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold while `mem_ready`=0.
  - In FETCH, `IR_write` and `PC_write` assert only in the cycle with `mem_ready`=1.
  - In MEMWRITE, `mem_write` stays asserted until the ready cycle.
- When undefined, the port is absent and every state lasts exactly 1 cycle.

## Test plan
- Reset, then ADD register (`op`=00, `funct`=001000, `cond`=1110, `rd`=0001):
  - `state_dbg` sequence 0,1,6,8,0.
  - `reg_write`=1 only in state 8; `ALU_control`=0.
- SUBS immediate (`funct`=100101) with `ALU_flags`=0100, then BEQ (`cond`=0000, `op`=10):
  - Flags become 0100.
  - BRANCH asserts `PC_write`=1. The same BNE asserts 0.
- LDR (`op`=01, `funct[0]`=1):
  - States 0,1,2,3,4.
  - `adr_src`=1 in state 3; `result_src`=01 and `reg_write`=1 in state 4.
- STRNE (`cond`=0001) with Z=1 stored:
  - Passes through MEMWRITE with `mem_write`=0.
  - Flags are unchanged.
- ADD with `rd`=1111:
  - `PC_write`=1 and `reg_write`=1 in ALUWB.
- Reset pulsed during EXECR:
  - All outputs are 0 immediately and `state_dbg`=0.
  - With the macro defined, `mem_ready`=0 for 3 cycles holds FETCH with `IR_write`=0 until ready.
